// File: rtl/apb_alu_master.sv
// ============================================================================
// Module      : apb_alu_master
// Description : APB requester for the ALU CSR slave. Turns single-word host
//               commands into APB setup/access transfers, absorbs wait states,
//               flags slave errors and timeouts, and returns one response per
//               command over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_alu_master #(
   parameter int REG_NUMBER     = 5,
   parameter int ADDR_WIDTH     = $clog2(REG_NUMBER),
   parameter int APB_BUS_SIZE   = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   // host command channel
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [APB_BUS_SIZE-1:0] cmd_wdata,
   // APB requester port
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [APB_BUS_SIZE-1:0] pwdata,
   input  logic                    pready,
   input  logic                    pslverr,
   input  logic [APB_BUS_SIZE-1:0] prdata,
   // host response channel
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [APB_BUS_SIZE-1:0] rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] tcnt;
   logic             accept;
   logic             timeout_hit;

   // A command is taken only when the host offers it and the block is idle.
   assign accept = cmd_valid && cmd_ready;

   // Last allowed access cycle passed without pready; pready in that same
   // cycle still wins because it is checked first in the next-state logic.
   assign timeout_hit = (state == ACCESS) && !pready && (tcnt == CNT_LAST);

   // State register; reset drops psel/penable/rsp_valid asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode of the APB transfer sequence.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (pready || timeout_hit) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control outputs are pure decodes of the state.
   always_comb begin
      psel      = 1'b0;
      penable   = 1'b0;
      rsp_valid = 1'b0;
      cmd_ready = 1'b0;
      case (state)
         IDLE:    cmd_ready = !rst;
         SETUP:   psel      = 1'b1;
         ACCESS:  begin
                     psel    = 1'b1;
                     penable = 1'b1;
                  end
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Address, direction and write data load only on acceptance and then hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwrite <= 1'b0;
         paddr  <= '0;
         pwdata <= '0;
      end else if (accept) begin
         pwrite <= cmd_write;
         paddr  <= cmd_addr;
         pwdata <= cmd_wdata;
      end
   end

   // Access-phase cycle counter: cleared on SETUP entry, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (accept) begin
         tcnt <= '0;
      end else if ((state == ACCESS) && (tcnt != {CNT_W{1'b1}})) begin
         tcnt <= tcnt + CNT_ONE;
      end
   end

   // Response fields are captured when the access phase ends and held in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (state == ACCESS) begin
         if (pready) begin
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
         end else if (timeout_hit) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_apb_alu_master.sv
// ============================================================================
// Module      : tb_apb_alu_master
// Description : Self-checking bench for apb_alu_master with a behavioural
//               APB slave and a transaction-level expected-response model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_alu_master;

   localparam int AW = 3;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pready = 1'b0;
   logic          pslverr = 1'b0;
   logic [DW-1:0] prdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err, rsp_timeout;

   int n_pass  = 0;
   int n_total = 0;

   // behavioural slave configuration and observations
   int            s_waits = 0;
   bit            s_err   = 0;
   bit            s_hang  = 0;
   logic [DW-1:0] s_rdata = '0;
   int            s_acc   = 0;
   logic [AW-1:0] s_paddr;
   logic [DW-1:0] s_pwdata;
   logic          s_pwrite;
   bit            s_stable  = 1;
   bit            s_overlap = 0;
   int            s_psel_cnt = 0;

   apb_alu_master #(
      .REG_NUMBER(5), .APB_BUS_SIZE(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pready(pready), .pslverr(pslverr), .prdata(prdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
   );

   always #5 clk = ~clk;

   // Slave: answers after s_waits access cycles (never if s_hang); outside
   // the access phase it drives noise that the master must ignore.
   always @(posedge clk) begin
      #1;
      if (rsp_valid && psel) s_overlap = 1;
      if (psel) s_psel_cnt++;
      if (psel && !penable) begin
         s_acc    = 0;
         s_paddr  = paddr;
         s_pwdata = pwdata;
         s_pwrite = pwrite;
         s_stable = 1;
      end
      if (psel && penable) begin
         if (paddr !== s_paddr || pwdata !== s_pwdata || pwrite !== s_pwrite) s_stable = 0;
         pready  = !s_hang && (s_acc == s_waits);
         pslverr = pready ? s_err : 1'($urandom);
         prdata  = pready ? s_rdata : $urandom;
         s_acc++;
      end else begin
         pready  = 1'($urandom);
         pslverr = 1'($urandom);
         prdata  = $urandom;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one command, waits (bounded) for its response, optionally holds
   // off rsp_ready for 'hold' cycles with a competing command offered.
   task automatic run_cmd(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input bit err, input logic [DW-1:0] rd,
                          input bit hang, input int hold,
                          output int lat, output logic o_err, output logic o_to,
                          output logic [DW-1:0] o_data, output bit hold_ok, output bit rdy_ok);
      @(negedge clk);
      s_waits = waits; s_err = err; s_rdata = rd; s_hang = hang;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      rdy_ok = (cmd_ready === 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      o_err = rsp_err; o_to = rsp_timeout; o_data = rsp_rdata;
      hold_ok = 1;
      cmd_valid = (hold > 0);
      cmd_write = ~w; cmd_wdata = ~d;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_err !== o_err || rsp_timeout !== o_to ||
             rsp_rdata !== o_data || cmd_ready !== 1'b0 || psel !== 1'b0) hold_ok = 0;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_total++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); else n_pass++;
      n_total++; if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0)
         $display("FAIL reset_ctrl got %b want 000000", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout}); else n_pass++;
      n_total++; if (paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0)
         $display("FAIL reset_data got %h/%h/%h want 0/0/0", paddr, pwdata, rsp_rdata); else n_pass++;
      rst = 1'b0;
      #1;
      n_total++; if (cmd_ready !== 1'b1) $display("FAIL release_cmd_ready got %b want 1", cmd_ready); else n_pass++;
   endtask

   task automatic test_zero_wait_write;
      int lat; logic e, t; logic [DW-1:0] dat; bit hok, rok;
      run_cmd(1'b1, 3'd0, 32'h0000_0001, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, lat, e, t, dat, hok, rok);
      n_total++; if (!rok) $display("FAIL wr_cmd_ready got 0 want 1"); else n_pass++;
      n_total++; if (lat !== 3) $display("FAIL wr_latency got %0d want 3", lat); else n_pass++;
      n_total++; if (s_acc !== 1) $display("FAIL wr_access_cycles got %0d want 1", s_acc); else n_pass++;
      n_total++; if ({e, t} !== 2'b00 || dat !== '0) $display("FAIL wr_rsp got err=%b to=%b data=%h want 0 0 0", e, t, dat); else n_pass++;
      n_total++; if (s_paddr !== 3'd0 || s_pwdata !== 32'h1 || s_pwrite !== 1'b1 || !s_stable)
         $display("FAIL wr_apb_fields got a=%h d=%h w=%b stable=%b want 0 1 1 1", s_paddr, s_pwdata, s_pwrite, s_stable); else n_pass++;
   endtask

   task automatic test_read_wait;
      int lat; logic e, t; logic [DW-1:0] dat; bit hok, rok;
      run_cmd(1'b0, 3'd3, 32'h1234_5678, 1, 1'b0, 32'h0000_0ABC, 1'b0, 0, lat, e, t, dat, hok, rok);
      n_total++; if (lat !== 4) $display("FAIL rd_latency got %0d want 4", lat); else n_pass++;
      n_total++; if (s_acc !== 2) $display("FAIL rd_access_cycles got %0d want 2", s_acc); else n_pass++;
      n_total++; if (dat !== 32'h0000_0ABC || e !== 1'b0 || t !== 1'b0)
         $display("FAIL rd_rsp got data=%h err=%b to=%b want 00000abc 0 0", dat, e, t); else n_pass++;
   endtask

   task automatic test_slave_error;
      int lat; logic e, t; logic [DW-1:0] dat; bit hok, rok;
      run_cmd(1'b0, 3'd1, 32'h0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 0, lat, e, t, dat, hok, rok);
      n_total++; if (e !== 1'b1 || t !== 1'b0) $display("FAIL err_flags got err=%b to=%b want 1 0", e, t); else n_pass++;
      n_total++; if (dat !== '0) $display("FAIL err_rdata got %h want 0", dat); else n_pass++;
      n_total++; if (lat !== 3) $display("FAIL err_latency got %0d want 3", lat); else n_pass++;
   endtask

   task automatic test_timeout;
      int lat; logic e, t; logic [DW-1:0] dat; bit hok, rok;
      run_cmd(1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h5555_AAAA, 1'b1, 0, lat, e, t, dat, hok, rok);
      n_total++; if (s_acc !== TO) $display("FAIL to_access_cycles got %0d want %0d", s_acc, TO); else n_pass++;
      n_total++; if (lat !== TO + 2) $display("FAIL to_latency got %0d want %0d", lat, TO + 2); else n_pass++;
      n_total++; if (e !== 1'b1 || t !== 1'b1 || dat !== '0)
         $display("FAIL to_rsp got err=%b to=%b data=%h want 1 1 0", e, t, dat); else n_pass++;
      // pready arriving in the very last allowed cycle beats the timeout
      run_cmd(1'b0, 3'd4, 32'h0, TO - 1, 1'b0, 32'h0BAD_F00D, 1'b0, 0, lat, e, t, dat, hok, rok);
      n_total++; if (s_acc !== TO || lat !== TO + 2) $display("FAIL late_ready_timing got acc=%0d lat=%0d want %0d %0d", s_acc, lat, TO, TO + 2); else n_pass++;
      n_total++; if (e !== 1'b0 || t !== 1'b0 || dat !== 32'h0BAD_F00D)
         $display("FAIL late_ready_rsp got err=%b to=%b data=%h want 0 0 0badf00d", e, t, dat); else n_pass++;
   endtask

   task automatic test_backpressure;
      int lat; logic e, t; logic [DW-1:0] dat; bit hok, rok; int psel_before;
      run_cmd(1'b0, 3'd0, 32'h0, 0, 1'b0, 32'hCAFE_0001, 1'b0, 5, lat, e, t, dat, hok, rok);
      n_total++; if (!hok) $display("FAIL bp_hold got unstable want stable"); else n_pass++;
      n_total++; if (dat !== 32'hCAFE_0001) $display("FAIL bp_rdata got %h want cafe0001", dat); else n_pass++;
      psel_before = s_psel_cnt;
      @(negedge clk);
      n_total++; if (cmd_ready !== 1'b1 || s_psel_cnt !== psel_before)
         $display("FAIL bp_after got cmd_ready=%b psel_cycles=%0d want 1 %0d", cmd_ready, s_psel_cnt, psel_before); else n_pass++;
   endtask

   task automatic test_random;
      int lat; logic e, t; logic [DW-1:0] dat; bit hok, rok;
      bit w, er; logic [AW-1:0] a; logic [DW-1:0] d, rd; int wt;
      int bad_lat, bad_rsp, bad_bus;
      bad_lat = 0; bad_rsp = 0; bad_bus = 0;
      for (int i = 0; i < 24; i++) begin
         w  = 1'($urandom);
         a  = AW'($urandom);
         d  = $urandom;
         rd = $urandom;
         wt = $urandom_range(0, 4);
         er = ($urandom_range(0, 3) == 0);
         run_cmd(w, a, d, wt, er, rd, 1'b0, 0, lat, e, t, dat, hok, rok);
         // transaction-level expectation: 3 cycles plus one per wait state,
         // read data only on an error-free read
         if (lat != 3 + wt || s_acc != wt + 1 || !rok) bad_lat++;
         if (e !== er || t !== 1'b0 || dat !== ((!w && !er) ? rd : 32'h0)) bad_rsp++;
         if (s_paddr !== a || s_pwrite !== w || s_pwdata !== d || !s_stable) bad_bus++;
      end
      n_total++; if (bad_lat != 0) $display("FAIL rand_timing got %0d bad want 0", bad_lat); else n_pass++;
      n_total++; if (bad_rsp != 0) $display("FAIL rand_response got %0d bad want 0", bad_rsp); else n_pass++;
      n_total++; if (bad_bus != 0) $display("FAIL rand_apb_fields got %0d bad want 0", bad_bus); else n_pass++;
   endtask

   task automatic test_reset_mid;
      int lat; logic e, t; logic [DW-1:0] dat; bit hok, rok; int seen; int psel_before;
      @(negedge clk);
      s_hang = 1'b1;
      cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 32'h7777_7777; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_total++; if (psel !== 1'b1 || penable !== 1'b1) $display("FAIL mid_in_access got psel=%b penable=%b want 1 1", psel, penable); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0)
         $display("FAIL mid_async_reset got %b want 0000", {psel, penable, rsp_valid, cmd_ready}); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      s_hang = 1'b0;
      #1;
      n_total++; if (cmd_ready !== 1'b1) $display("FAIL mid_release_ready got %b want 1", cmd_ready); else n_pass++;
      seen = 0;
      psel_before = s_psel_cnt;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) seen++;
      end
      n_total++; if (seen != 0 || s_psel_cnt != psel_before)
         $display("FAIL mid_no_response got rsp_cycles=%0d psel_cycles=%0d want 0 0", seen, s_psel_cnt - psel_before); else n_pass++;
      run_cmd(1'b0, 3'd1, 32'h0, 0, 1'b0, 32'h0101_0101, 1'b0, 0, lat, e, t, dat, hok, rok);
      n_total++; if (lat !== 3 || e !== 1'b0 || dat !== 32'h0101_0101)
         $display("FAIL mid_next_cmd got lat=%0d err=%b data=%h want 3 0 01010101", lat, e, dat); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_zero_wait_write();
      test_read_wait();
      test_slave_error();
      test_timeout();
      test_backpressure();
      test_random();
      test_reset_mid();
      n_total++; if (s_overlap) $display("FAIL rsp_valid_with_psel got 1 want 0"); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/apb_alu_master.md
# apb_alu_master

APB requester that drives the ALU control/status register slave. It converts single-word command requests from a host-side sequencer or testbench into APB setup/access transfers. It absorbs slave wait states, detects errors and timeouts, and returns one response per command over a valid/ready handshake. It sits between the host command source and the ALU CSR APB slave port.

## Interface
- `REG_NUMBER`, 5: number of slave registers; sets the address width.
- `ADDR_WIDTH`, `$clog2(REG_NUMBER)`: width of the command and APB address.
- `APB_BUS_SIZE`, 32: data width of `wdata`/`rdata`.
- `TIMEOUT_CYCLES`, 16: maximum number of access-phase cycles waiting for `pready`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: a command is offered.
- `cmd_ready` out 1: the block accepts a command this cycle.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in `ADDR_WIDTH`: register index.
- `cmd_wdata` in `APB_BUS_SIZE`: write data.
- `psel`, `penable`, `pwrite` out 1 each: APB control.
- `paddr` out `ADDR_WIDTH`: APB address.
- `pwdata` out `APB_BUS_SIZE`: APB write data.
- `pready` in 1: slave ready.
- `pslverr` in 1: slave error.
- `prdata` in `APB_BUS_SIZE`: slave read data.
- `rsp_valid` out 1: a response is held.
- `rsp_ready` in 1: the host consumes the response.
- `rsp_rdata` out `APB_BUS_SIZE`: read data; 0 for writes and errors.
- `rsp_err` out 1: slave error or timeout.
- `rsp_timeout` out 1: the transfer was aborted because `pready` never arrived.

## Operation
**FSM states:** IDLE, SETUP, ACCESS, RESP.
- **IDLE:** `cmd_ready` = 1 (combinational decode of state, forced to 0 while `rst` is high). On `cmd_valid && cmd_ready`:
  - register `cmd_write`, `cmd_addr` and `cmd_wdata` into `pwrite`, `paddr` and `pwdata`;
  - go to SETUP.
- **SETUP:** `psel` = 1, `penable` = 0. Always go to ACCESS next; exactly one cycle.
- **ACCESS:** `psel` = 1, `penable` = 1. The timeout counter increments each cycle.
  - `pready` = 1: capture `pslverr` into `rsp_err`. Capture `prdata` into `rsp_rdata` only if `!pwrite && !pslverr`, otherwise load 0. Set `rsp_timeout` = 0 and go to RESP.
  - `pready` = 0 with the counter at `TIMEOUT_CYCLES`-1: set `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0, and go to RESP.
- **RESP:** `psel` = `penable` = 0, `rsp_valid` = 1. On `rsp_ready`, go to IDLE. Response fields are held stable until consumed.

**Signal rules:**
- `paddr`, `pwrite` and `pwdata` are loaded only on command acceptance. They stay stable through SETUP and ACCESS and hold their last value afterwards.
- No local address or opcode checking. Out-of-range addresses and illegal accesses are forwarded; the slave reports them via `pslverr`.
- `rsp_valid` is never asserted while `psel` = 1. At most one command is outstanding.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide. It clears on entry to SETUP and saturates without wrap-around.

## Timing
**Reset values:** all outputs 0, state IDLE, counter 0. `cmd_ready` is 0 during reset and 1 in the first cycle after release.

**Latency** (accept at edge N):
- SETUP during cycle N+1.
- ACCESS from cycle N+2.
- With a zero-wait slave, `rsp_valid` rises in cycle N+3.
- Each wait state adds one cycle.
- Minimum command-to-command spacing is 4 cycles (accept, SETUP, ACCESS, RESP consumed in its first cycle).
- The slave inserts one wait state on reads of the result and status registers (addresses 3 and 4), so read latency to `rsp_valid` is 4 cycles.

**Handshake:** `pready` is sampled only in ACCESS. A `pready` or `pslverr` seen in SETUP or IDLE is ignored.

**Simultaneous events:**
- `pready` and the timeout in the same cycle: `pready` wins, so `rsp_timeout` = 0.
- `cmd_valid` while in RESP: not accepted until IDLE.

**Reset mid-transfer:** `psel`, `penable` and `rsp_valid` fall asynchronously. Any pending response is discarded, and no response is produced for the aborted command.

## Test plan
- **Zero-wait write:** write addr 0, wdata 0x0000_0001, `pready` high in the first ACCESS cycle. Expect SETUP at N+1, ACCESS at N+2, `rsp_valid` at N+3, `rsp_err` = 0, `rsp_rdata` = 0, `paddr`/`pwdata` stable throughout.
- **Read with one wait state:** read addr 3, `pready` low then high, `prdata` = 0x0000_0ABC. Expect 2 ACCESS cycles, `rsp_rdata` = 0x0000_0ABC, `rsp_err` = 0.
- **Slave error:** read addr 1 with `pslverr` = 1 and `pready` = 1, `prdata` = 0xFFFF_FFFF. Expect `rsp_err` = 1, `rsp_timeout` = 0, `rsp_rdata` = 0.
- **Timeout:** `pready` held 0. Expect exactly 16 ACCESS cycles, then `psel` = 0, `rsp_err` = 1, `rsp_timeout` = 1. Also drive `pready` = 1 in the 16th cycle and expect a normal completion with `rsp_timeout` = 0.
- **Backpressure:** `rsp_ready` held low for 5 cycles with `cmd_valid` high. Expect `rsp_valid` and response data stable, `cmd_ready` = 0, and no new `psel` until the response is consumed.
- **Reset mid-transfer:** assert `rst` during ACCESS. Expect `psel`/`penable` = 0 in the same cycle, no `rsp_valid` after release, `cmd_ready` = 1 one cycle after release, and the next command completes normally.
